// File: rtl/seg7_scan_controller.sv
// Scan controller for an N-digit common-cathode 7-segment display sharing one BCD decoder.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    S_GUARD = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  function automatic logic [3:0] nibble_at(input logic [DW-1:0] v, input logic [IW-1:0] idx);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        r = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_DIGITS-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i] = (idx == IW'(i));
    end
    return r;
  endfunction

`ifdef SEG7_SCAN_LZB_EN
  // Digit idx>0 is blanked when its nibble and every higher nibble are zero.
  function automatic logic lz_blank(input logic [DW-1:0] v, input logic [IW-1:0] idx);
    logic r;
    logic zero_above;
    r          = 1'b0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'h0) begin
        zero_above = 1'b0;
      end
      if (idx == IW'(i)) begin
        r = zero_above;
      end
    end
    return r;
  endfunction
`endif

  state_t            state_r, state_nxt_s;
  logic [IW-1:0]     idx_r, idx_nxt_s;
  logic [CW-1:0]     cnt_r, cnt_nxt_s;
  logic [DW-1:0]     active_r, active_nxt_s;
  logic [DW-1:0]     shadow_r, shadow_nxt_s;
  logic              pending_r, pending_nxt_s;
  logic              commit_s, accept_s, enter_show_s, blank_s;
  logic              frame_done_nxt_s;
  logic [NUM_DIGITS-1:0] digit_en_nxt_s;
  logic [6:0]        seg_nxt_s;

  // Scan sequencing: guard gap, then dwell, then advance to the next digit.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_GUARD: begin
        if (cnt_r == GUARD_LAST) begin
          state_nxt_s = S_SHOW;
          cnt_nxt_s   = {CW{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + CW'(1'b1);
        end
      end
      S_SHOW: begin
        if (cnt_r == DWELL_LAST) begin
          state_nxt_s = S_GUARD;
          cnt_nxt_s   = {CW{1'b0}};
          if (idx_r == IDX_LAST) begin
            idx_nxt_s = {IW{1'b0}};
          end else begin
            idx_nxt_s = idx_r + IW'(1'b1);
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1'b1);
        end
      end
      default: begin
        state_nxt_s = S_GUARD;
        idx_nxt_s   = {IW{1'b0}};
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Load handshake and tear-free frame commit from shadow to active.
  always_comb begin
    commit_s = (state_r == S_SHOW) && (idx_r == IDX_LAST) && (cnt_r == DWELL_LAST);
    accept_s = load_valid && load_ready;
    if (accept_s) begin
      shadow_nxt_s  = load_bcd;
      pending_nxt_s = 1'b1;
    end else if (commit_s) begin
      shadow_nxt_s  = shadow_r;
      pending_nxt_s = 1'b0;
    end else begin
      shadow_nxt_s  = shadow_r;
      pending_nxt_s = pending_r;
    end
    if (commit_s && pending_r) begin
      active_nxt_s = shadow_r;
    end else begin
      active_nxt_s = active_r;
    end
  end

  // Digit enable and segment capture; seg_in is stable since bcd_out held through the guard.
  always_comb begin
    enter_show_s     = (state_r == S_GUARD) && (state_nxt_s == S_SHOW);
    frame_done_nxt_s = (state_nxt_s == S_SHOW) && (idx_nxt_s == IDX_LAST) &&
                       (cnt_nxt_s == DWELL_LAST);
`ifdef SEG7_SCAN_LZB_EN
    blank_s = lz_blank(active_r, idx_r);
`else
    blank_s = 1'b0;
`endif
    if (enter_show_s) begin
      digit_en_nxt_s = blank_s ? {NUM_DIGITS{1'b0}} : onehot(idx_r);
      seg_nxt_s      = seg_in;
    end else if (state_nxt_s == S_SHOW) begin
      digit_en_nxt_s = digit_en;
      seg_nxt_s      = seg_out;
    end else begin
      digit_en_nxt_s = {NUM_DIGITS{1'b0}};
      seg_nxt_s      = 7'b000_0000;
    end
  end

  // State, data and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_GUARD;
      idx_r      <= {IW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      active_r   <= {DW{1'b0}};
      shadow_r   <= {DW{1'b0}};
      pending_r  <= 1'b0;
      load_ready <= 1'b1;
      bcd_out    <= 4'h0;
      seg_out    <= 7'b000_0000;
      digit_en   <= {NUM_DIGITS{1'b0}};
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      cnt_r      <= cnt_nxt_s;
      active_r   <= active_nxt_s;
      shadow_r   <= shadow_nxt_s;
      pending_r  <= pending_nxt_s;
      load_ready <= !pending_nxt_s;
      bcd_out    <= nibble_at(active_nxt_s, idx_nxt_s);
      seg_out    <= seg_nxt_s;
      digit_en   <= digit_en_nxt_s;
      frame_done <= frame_done_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller (4 digits, dwell 4, guard 2, 24-cycle frame).
module tb_seg7_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_bcd = 16'h0000;
  logic [3:0]  bcd_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] en;
    logic [6:0] seg;
    logic [3:0] bcd;
  } slot_t;

  slot_t exp_q[$];

  seg7_scan_controller #(
    .NUM_DIGITS(4),
    .DWELL_CYCLES(4),
    .GUARD_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_bcd(load_bcd),
    .bcd_out(bcd_out),
    .seg_in(seg_in),
    .seg_out(seg_out),
    .digit_en(digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // External decoder {a,b,c,d,e,f,g}; codes above 9 are blank.
  always_comb begin
    case (bcd_out)
      4'd0:    seg_in = 7'b1111110;
      4'd1:    seg_in = 7'b0110000;
      4'd2:    seg_in = 7'b1101101;
      4'd3:    seg_in = 7'b1111001;
      4'd4:    seg_in = 7'b0110011;
      4'd5:    seg_in = 7'b1011011;
      4'd6:    seg_in = 7'b1011111;
      4'd7:    seg_in = 7'b1110000;
      4'd8:    seg_in = 7'b1111111;
      4'd9:    seg_in = 7'b1111011;
      default: seg_in = 7'b0000000;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected lit slots of one frame, digit 0 first; segment patterns are written out by hand.
  task automatic push_frame(input logic [15:0] v, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    logic [6:0] segs [4];
    logic [3:0] en;
    logic       blank;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int i = 0; i < 4; i++) begin
      blank = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
      if (i > 0 && (v >> (4 * i)) == 16'h0000) blank = 1'b1;
`endif
      en = 4'b0001 << i;
      if (!blank) exp_q.push_back('{en: en, seg: segs[i], bcd: v[4*i +: 4]});
    end
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 60);
    check("frame_done_seen", {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_en(input logic [3:0] en);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (digit_en !== en && n < 60);
    check("digit_en_seen", {28'd0, digit_en}, {28'd0, en});
  endtask

  // Offer a value and hold it until accepted; returns just after the accepting edge.
  task automatic load_hold(input logic [15:0] v);
    int n;
    load_bcd   = v;
    load_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_ready && n < 80);
    check("load_accept", {31'd0, load_ready}, 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per lit slot, checks dwell length and frame period.
  int         run_len = 0;
  int         fcnt    = 0;
  logic [3:0] prev_en = 4'b0000;
  initial begin
    slot_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len = 0;
        fcnt    = 0;
        prev_en = 4'b0000;
      end else begin
        fcnt++;
        if (frame_done) begin
          check("frame_period", fcnt, 32'd24);
          fcnt = 0;
        end
        if (digit_en != 4'b0000) begin
          if (prev_en == 4'b0000) begin
            run_len = 1;
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("slot_en", {28'd0, digit_en}, {28'd0, e.en});
              check("slot_seg", {25'd0, seg_out}, {25'd0, e.seg});
              check("slot_bcd", {28'd0, bcd_out}, {28'd0, e.bcd});
            end
          end else begin
            check("slot_hold", {28'd0, digit_en}, {28'd0, prev_en});
            run_len++;
          end
        end else if (prev_en != 4'b0000) begin
          check("dwell_len", run_len, 32'd4);
        end
        prev_en = digit_en;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for three edges, then the first guard gap and first lit slot.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(16'h0000, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
    @(negedge clk);
    check("rst_digit_en", {28'd0, digit_en}, 32'd0);
    check("rst_seg_out", {25'd0, seg_out}, 32'd0);
    check("rst_bcd_out", {28'd0, bcd_out}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    check("guard2_digit_en", {28'd0, digit_en}, 32'd0);
    @(negedge clk);
    check("first_lit_en", {28'd0, digit_en}, 32'd1);
    wait_frame_done();

    // Mid-frame load: old value finishes this frame, new value shows the next.
    push_frame(16'h0000, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
    push_frame(16'h1234, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011);
    repeat (10) @(posedge clk);
    #1;
    load_hold(16'h1234);
    @(negedge clk);
    check("ready_drop", {31'd0, load_ready}, 32'd0);
    wait_frame_done();
    check("ready_at_commit", {31'd0, load_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_commit", {31'd0, load_ready}, 32'd1);

    // Back-to-back loads: second is held off while pending, then one frame each.
    push_frame(16'h5678, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111);
    push_frame(16'h9012, 7'b1111011, 7'b1111110, 7'b0110000, 7'b1101101);
    @(posedge clk);
    #1;
    load_hold(16'h5678);
    @(negedge clk);
    check("ready_pending", {31'd0, load_ready}, 32'd0);
    load_hold(16'h9012);

    // Leading zeros, then an invalid nibble in digit 2.
    push_frame(16'h0007, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1110000);
    load_hold(16'h0007);
    push_frame(16'h0A35, 7'b1111110, 7'b0000000, 7'b1111001, 7'b1011011);
    load_hold(16'h0A35);

    // Leave a value pending, then reset during digit 2 of the 0A35 frame.
    load_hold(16'h4321);
    wait_en(4'b0100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    push_frame(16'h0000, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
    @(negedge clk);
    check("pre_rst_ready", {31'd0, load_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_digit_en", {28'd0, digit_en}, 32'd0);
    check("mid_rst_seg_out", {25'd0, seg_out}, 32'd0);
    check("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    check("mid_rst_bcd", {28'd0, bcd_out}, 32'd0);
    wait_frame_done();
    check("queue_drained_1", exp_q.size(), 32'd0);
    push_frame(16'h0000, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
    wait_frame_done();
    check("queue_drained_2", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
